// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes PS/2 set-2 bytes into held-key state, a BCD press count and hex display digits
module ps2_key_tracker #(
  parameter int NUM_DIGITS = 8,
  parameter int CNT_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              kbd_data,
  input  logic                    kbd_ready,
  input  logic                    kbd_overflow,
  output logic                    kbd_nextdata_n,
  output logic                    kbd_clrn,
  output logic [4*NUM_DIGITS-1:0] digit_data,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    key_down,
  output logic [8:0]              key_code
);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t state, next;
  logic [4*CNT_DIGITS-1:0] count, count_inc;
  logic key_lit, cnt_lit, take, ovf, ctl, mk, brk, hit, carry;
  logic [8:0] code;
  // clrn gating keeps the clear pulse one cycle long and keeps pops out of the clear cycle
  assign ovf = kbd_overflow && kbd_clrn;
  assign take = kbd_ready && kbd_nextdata_n && kbd_clrn && !kbd_overflow;
  assign ctl = kbd_data == 8'hE0 || kbd_data == 8'hF0;
  assign code = {state == EXT || state == EXT_BRK, kbd_data};
  assign hit = key_down && key_code == code;
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  always_comb begin
    next = state;
    mk = 1'b0;
    brk = 1'b0;
    if (ovf) next = IDLE;
    else if (take)
      case (state)
        IDLE: begin
          next = kbd_data == 8'hE0 ? EXT : kbd_data == 8'hF0 ? BRK : IDLE;
          mk = !ctl;
        end
        EXT: begin
          next = kbd_data == 8'hF0 ? EXT_BRK : kbd_data == 8'hE0 ? EXT : IDLE;
          mk = !ctl;
        end
        default: begin
          next = IDLE;
          brk = !ctl;
        end
      endcase
  end
  always_comb begin
    count_inc = count;
    carry = 1'b1;
    for (int i = 0; i < CNT_DIGITS; i++) begin
      if (carry) count_inc[4*i+:4] = count[4*i+:4] == 4'd9 ? 4'd0 : count[4*i+:4] + 4'd1;
      carry = carry && count[4*i+:4] == 4'd9;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_clrn <= 1'b0;
      kbd_nextdata_n <= 1'b1;
      key_down <= 1'b0;
      key_code <= '0;
      count <= '0;
      key_lit <= 1'b0;
      cnt_lit <= 1'b0;
    end else begin
      kbd_clrn <= !ovf;
      kbd_nextdata_n <= !take;
      if (ovf) begin
        key_down <= 1'b0;
        key_lit <= 1'b0;
      end else if (mk && !hit) begin
        key_code <= code;
        key_down <= 1'b1;
        count <= count_inc;
        key_lit <= 1'b1;
        cnt_lit <= 1'b1;
      end else if (brk && hit) begin
        key_down <= 1'b0;
        key_lit <= 1'b0;
      end
    end
  end
  always_comb begin
    digit_data = '0;
    digit_data[7:0] = key_code[7:0];
    digit_data[8+:4*CNT_DIGITS] = count;
    digit_data[4*CNT_DIGITS+8+:4] = {3'b000, key_code[8]};
    digit_en = '0;
    digit_en[1:0] = {2{key_lit}};
    digit_en[2+:CNT_DIGITS] = {CNT_DIGITS{cnt_lit}};
    digit_en[CNT_DIGITS+2] = key_lit;
  end
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed and randomized checks of the PS/2 key tracker against a byte-level model
module tb_ps2_key_tracker;
  localparam int ND = 8;
  localparam int CD = 2;
  logic clk = 0, reset = 1, kbd_ready = 0, kbd_overflow = 0;
  logic [7:0] kbd_data = '0;
  logic kbd_nextdata_n, kbd_clrn, key_down;
  logic [4*ND-1:0] digit_data;
  logic [ND-1:0] digit_en;
  logic [8:0] key_code;
  int n_cmp = 0, n_err = 0;
  logic m_e0, m_f0, m_down, m_klit, m_clit;
  logic [8:0] m_code;
  int m_count;

  ps2_key_tracker #(.NUM_DIGITS(ND), .CNT_DIGITS(CD)) dut (
    .clk(clk), .reset(reset), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n), .kbd_clrn(kbd_clrn),
    .digit_data(digit_data), .digit_en(digit_en), .key_down(key_down), .key_code(key_code)
  );

  always #5 clk = ~clk;

  function automatic logic [49:0] obs();
    return {key_down, key_code, digit_en, digit_data};
  endfunction

  function automatic logic [49:0] model_vec();
    logic [31:0] d;
    logic [7:0] en;
    int c;
    d = '0;
    en = '0;
    c = m_count;
    d[7:0] = m_code[7:0];
    for (int k = 0; k < CD; k++) begin
      d[8+4*k+:4] = 4'(c % 10);
      c = c / 10;
    end
    d[8+4*CD+:4] = {3'b000, m_code[8]};
    en[1:0] = {2{m_klit}};
    en[2+:CD] = {CD{m_clit}};
    en[CD+2] = m_klit;
    return {m_down, m_code, en, d};
  endfunction

  task automatic model_reset();
    m_e0 = 0; m_f0 = 0; m_down = 0; m_klit = 0; m_clit = 0; m_code = '0; m_count = 0;
  endtask

  // pending prefix is remembered as "seen E0" / "seen F0"; a second F0 or an E0 after F0 is an error
  task automatic model_byte(input logic [7:0] b);
    logic [8:0] c;
    if (b == 8'hF0 || b == 8'hE0) begin
      if (m_f0) begin m_e0 = 0; m_f0 = 0; end
      else if (b == 8'hF0) m_f0 = 1;
      else m_e0 = 1;
    end else begin
      c = {m_e0, b};
      if (!m_f0) begin
        if (!(m_down && m_code == c)) begin
          m_code = c; m_down = 1; m_count = (m_count + 1) % (10 ** CD); m_klit = 1; m_clit = 1;
        end
      end else if (m_down && m_code == c) begin
        m_down = 0; m_klit = 0;
      end
      m_e0 = 0; m_f0 = 0;
    end
  endtask

  task automatic model_ovf();
    m_e0 = 0; m_f0 = 0; m_down = 0; m_klit = 0;
  endtask

  task automatic do_reset();
    reset = 1; kbd_ready = 0; kbd_overflow = 0;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    while (!(kbd_nextdata_n === 1'b1 && kbd_clrn === 1'b1) && w < 8) begin
      @(posedge clk); #1; w++;
    end
    if (w == 8) begin
      n_cmp++; n_err++;
      $display("FAIL send_wait: nextdata_n=%b clrn=%b, required both 1 within 8 cycles", kbd_nextdata_n, kbd_clrn);
    end
    kbd_data = b; kbd_ready = 1;
    @(posedge clk); #1;
    kbd_ready = 0;
    model_byte(b);
  endtask

  task automatic do_overflow(input logic with_ready);
    kbd_overflow = 1; kbd_ready = with_ready; kbd_data = 8'h1C;
    @(posedge clk); #1;
    kbd_overflow = 0; kbd_ready = 0;
    model_ovf();
  endtask

  task automatic test_reset();
    reset = 1; kbd_ready = 1; kbd_data = 8'h1C;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if ({kbd_clrn, kbd_nextdata_n, obs()} !== {1'b0, 1'b1, 50'b0}) begin
      n_err++;
      $display("FAIL reset_state: got %h, required %h", {kbd_clrn, kbd_nextdata_n, obs()}, {1'b0, 1'b1, 50'b0});
    end
    kbd_ready = 0; reset = 0;
    @(posedge clk); #1;
    n_cmp++;
    if ({kbd_clrn, kbd_nextdata_n} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_release: clrn,nextdata_n=%b, required 11", {kbd_clrn, kbd_nextdata_n});
    end
    model_reset();
  endtask

  task automatic test_pop();
    do_reset();
    kbd_data = 8'hE0; kbd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({kbd_clrn, kbd_nextdata_n} !== {1'b1, 1'(i % 2)}) begin
        n_err++;
        $display("FAIL pop_cadence[%0d]: clrn,nextdata_n=%b, required %b", i, {kbd_clrn, kbd_nextdata_n}, {1'b1, 1'(i % 2)});
      end
    end
    kbd_ready = 0;
    model_byte(8'hE0); model_byte(8'hE0);
    send_byte(8'h75);
    n_cmp++;
    if (obs() !== model_vec()) begin
      n_err++;
      $display("FAIL pop_e0e0_75: got %h, required %h", obs(), model_vec());
    end
  endtask

  task automatic test_make_break();
    do_reset();
    send_byte(8'h1C);
    n_cmp++;
    if (obs() !== {1'b1, 9'h01C, 8'h1F, 32'h0000011C}) begin
      n_err++;
      $display("FAIL make_1c: got %h, required %h", obs(), {1'b1, 9'h01C, 8'h1F, 32'h0000011C});
    end
    send_byte(8'hF0); send_byte(8'h1C);
    n_cmp++;
    if (obs() !== {1'b0, 9'h01C, 8'h0C, 32'h0000011C}) begin
      n_err++;
      $display("FAIL break_1c: got %h, required %h", obs(), {1'b0, 9'h01C, 8'h0C, 32'h0000011C});
    end
  endtask

  task automatic test_typematic();
    do_reset();
    repeat (3) send_byte(8'h1C);
    n_cmp++;
    if (obs() !== {1'b1, 9'h01C, 8'h1F, 32'h0000011C}) begin
      n_err++;
      $display("FAIL typematic_held: got %h, required %h", obs(), {1'b1, 9'h01C, 8'h1F, 32'h0000011C});
    end
    send_byte(8'hF0); send_byte(8'h1C);
    n_cmp++;
    if (obs() !== {1'b0, 9'h01C, 8'h0C, 32'h0000011C}) begin
      n_err++;
      $display("FAIL typematic_release: got %h, required %h", obs(), {1'b0, 9'h01C, 8'h0C, 32'h0000011C});
    end
  endtask

  task automatic test_extended();
    do_reset();
    send_byte(8'hE0); send_byte(8'h75);
    n_cmp++;
    if (obs() !== {1'b1, 9'h175, 8'h1F, 32'h00010175}) begin
      n_err++;
      $display("FAIL ext_make: got %h, required %h", obs(), {1'b1, 9'h175, 8'h1F, 32'h00010175});
    end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    n_cmp++;
    if (obs() !== {1'b0, 9'h175, 8'h0C, 32'h00010175}) begin
      n_err++;
      $display("FAIL ext_break: got %h, required %h", obs(), {1'b0, 9'h175, 8'h0C, 32'h00010175});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      send_byte(8'(i)); send_byte(8'hF0); send_byte(8'(i));
      if (i == 99) begin
        n_cmp++;
        if (digit_data[15:8] !== 8'h99 || obs() !== model_vec()) begin
          n_err++;
          $display("FAIL wrap_99: got %h, required %h", obs(), model_vec());
        end
      end
    end
    n_cmp++;
    if (digit_data[15:8] !== 8'h00 || obs() !== model_vec()) begin
      n_err++;
      $display("FAIL wrap_00: got %h, required %h", obs(), model_vec());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send_byte(8'h1C); send_byte(8'hF0);
    @(posedge clk); #1;
    do_overflow(1'b1);
    n_cmp++;
    if ({kbd_clrn, kbd_nextdata_n, obs()} !== {2'b01, 1'b0, 9'h01C, 8'h0C, 32'h0000011C}) begin
      n_err++;
      $display("FAIL ovf_pulse: got %h, required %h", {kbd_clrn, kbd_nextdata_n, obs()}, {2'b01, 1'b0, 9'h01C, 8'h0C, 32'h0000011C});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({kbd_clrn, kbd_nextdata_n} !== 2'b11) begin
      n_err++;
      $display("FAIL ovf_release: clrn,nextdata_n=%b, required 11", {kbd_clrn, kbd_nextdata_n});
    end
    send_byte(8'h1C);
    n_cmp++;
    if (obs() !== {1'b1, 9'h01C, 8'h1F, 32'h0000021C}) begin
      n_err++;
      $display("FAIL ovf_idle_make: got %h, required %h", obs(), {1'b1, 9'h01C, 8'h1F, 32'h0000021C});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'hE0);
    do_reset();
    send_byte(8'h1C);
    n_cmp++;
    if (obs() !== {1'b1, 9'h01C, 8'h1F, 32'h0000011C}) begin
      n_err++;
      $display("FAIL reset_mid_seq: got %h, required %h", obs(), {1'b1, 9'h01C, 8'h1F, 32'h0000011C});
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [6] = '{8'hE0, 8'hF0, 8'h1C, 8'h75, 8'h12, 8'h29};
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_overflow(1'($urandom_range(0, 1)));
        n_cmp++;
        if ({kbd_clrn, kbd_nextdata_n, obs()} !== {2'b01, model_vec()}) begin
          n_err++;
          $display("FAIL rand_ovf[%0d]: got %h, required %h", i, {kbd_clrn, kbd_nextdata_n, obs()}, {2'b01, model_vec()});
        end
      end else begin
        send_byte(pool[$urandom_range(0, 5)]);
        n_cmp++;
        if ({kbd_nextdata_n, obs()} !== {1'b0, model_vec()}) begin
          n_err++;
          $display("FAIL rand_byte[%0d]: got %h, required %h", i, {kbd_nextdata_n, obs()}, {1'b0, model_vec()});
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_pop();
    test_make_break();
    test_typematic();
    test_extended();
    test_wrap();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, meaning the number of display digits driven (legal range CNT_DIGITS+3 to 8).
REQ-002 SHALL have parameter CNT_DIGITS, default 2, meaning the number of BCD key-press counter digits (legal range 1 to 4).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port kbd_data, input, 8 bits: byte from the PS/2 receiver FIFO head.
REQ-006 SHALL have port kbd_ready, input, 1 bit: the receiver FIFO is non-empty.
REQ-007 SHALL have port kbd_overflow, input, 1 bit: the receiver FIFO has overflowed.
REQ-008 SHALL have port kbd_nextdata_n, output, 1 bit: active-low pop strobe to the receiver.
REQ-009 SHALL have port kbd_clrn, output, 1 bit: active-low clear to the receiver.
REQ-010 SHALL have port digit_data, output, 4*NUM_DIGITS bits: hex nibble per digit, digit i at bits [4i+3:4i].
REQ-011 SHALL have port digit_en, output, NUM_DIGITS bits: per-digit enable (1 = lit).
REQ-012 SHALL have port key_down, output, 1 bit: a key is currently held.
REQ-013 SHALL have port key_code, output, 9 bits: {ext, scancode} of the held or last-pressed key.

Function
REQ-014 SHALL pop bytes as follows: when kbd_ready=1 and kbd_nextdata_n=1 in cycle N, sample kbd_data in cycle N and drive kbd_nextdata_n=0 for exactly cycle N+1; kbd_ready is ignored while kbd_nextdata_n=0, giving at most one byte per 2 cycles.
REQ-015 SHALL implement the decode FSM with states IDLE, EXT, BRK and EXT_BRK.
REQ-016 SHALL apply these transitions in IDLE: E0 goes to EXT; F0 goes to BRK; any other byte c raises make(c, ext=0) and stays in IDLE.
REQ-017 SHALL apply these transitions in EXT: F0 goes to EXT_BRK; E0 stays in EXT; any other byte c raises make(c, ext=1) and goes to IDLE.
REQ-018 SHALL apply these transitions in BRK and EXT_BRK: any byte c other than E0/F0 raises break(c, ext=0 or 1 respectively) and goes to IDLE; E0 or F0 is a protocol error, goes to IDLE, and raises no event.
REQ-019 SHALL treat make(c, e) with key_down=1 and key_code=={e,c} as a typematic repeat, with no state change.
REQ-020 SHALL handle any other make(c, e) by setting key_code={e,c} and key_down=1, incrementing the BCD counter, and lighting all digits.
REQ-021 SHALL increment the BCD counter in decimal with per-digit carry, wrapping from all 9s to all 0s (e.g. 99 to 00 for CNT_DIGITS=2).
REQ-022 SHALL handle break(c, e) with key_down=1 and key_code=={e,c} by clearing key_down and clearing digit_en for the scancode and ext digits only; counter digits stay lit.
REQ-023 SHALL ignore a break(c, e) that does not match key_code.
REQ-024 SHALL lay out digit_data as: digits 1:0 = key_code[7:0] in hex; digits CNT_DIGITS+1:2 = BCD count; digit CNT_DIGITS+2 = key_code[8]; all higher digits = 0 with enable 0.
REQ-025 SHALL register all outputs, so that display and key_* outputs reflect a byte popped in cycle N from cycle N+1.
REQ-026 SHALL respond to kbd_overflow=1 by driving kbd_clrn=0 for exactly one cycle, forcing the FSM to IDLE, clearing key_down and blanking the scancode and ext digits; the count is preserved.
REQ-027 SHALL give overflow priority over a simultaneous kbd_ready; that byte is discarded and not popped.
REQ-028 SHALL not assert kbd_nextdata_n=0 in the same cycle as kbd_clrn=0.

Reset
REQ-029 SHALL, while reset=1, set kbd_clrn=0, kbd_nextdata_n=1, digit_en=0, digit_data=0, key_down=0, key_code=0, count=0 and FSM=IDLE.
REQ-030 SHALL, on the first cycle after reset deasserts, set kbd_clrn=1.
REQ-031 SHALL abandon any pending multi-byte sequence when reset is asserted mid-sequence, without emitting an event.

Verification
REQ-032 Bench SHALL cover: bytes 1C, F0, 1C -> key_code=01C, count digits 01, key_down 1 then 0; digits 0,1,4 go dark and digits 2,3 stay lit.
REQ-033 Bench SHALL cover: bytes 1C, 1C, 1C (typematic), F0, 1C -> count 01, not 03.
REQ-034 Bench SHALL cover: bytes E0, 75, E0, F0, 75 -> key_code=175, digit 4 = 1 while held, count incremented once.
REQ-035 Bench SHALL cover: 100 distinct make/break pairs with CNT_DIGITS=2 -> count wraps to 00.
REQ-036 Bench SHALL cover: kbd_overflow=1 together with kbd_ready=1 while in BRK -> kbd_clrn low for 1 cycle, no pop, FSM IDLE, key_down 0, count unchanged.
REQ-037 Bench SHALL cover: reset asserted between E0 and the next byte, then byte 1C -> make(1C, ext=0), key_code=01C, count 01.
